// File: rtl/tcp_sched_pkg.sv
// Shared types for the per-flow TCP transmit scheduler: command opcodes,
// FSM states and the grant record.
package tcp_sched_pkg;

  localparam int MAX_TCP_FLOWS  = 64;
  localparam int SCHED_OP_W     = 2;
  localparam int SCHED_FLOWID_W = $clog2(MAX_TCP_FLOWS);

  typedef enum logic [SCHED_OP_W-1:0] {
    SCHED_NOP      = 2'd0,
    SCHED_SET_DATA = 2'd1,
    SCHED_SET_RT   = 2'd2,
    SCHED_CLR_ALL  = 2'd3
  } sched_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [SCHED_FLOWID_W-1:0] flowid;
    logic                      rt;
  } sched_grant_struct;

endpackage

// File: rtl/rr_prio_enc.sv
// Round-robin priority encoder: finds the first set request bit at or after
// i_start, wrapping modulo W (W must be a power of two, at least 2).
module rr_prio_enc #(
  parameter int W  = 64,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] w_pos;

  // Scan from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      w_pos = i_start + IW'(i);
      if (i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/tcp_tx_flow_sched.sv
// Per-flow TX scheduler: pending data/retransmit bits per flow, one grant at a
// time, retransmits first, round-robin within each class.
module tcp_tx_flow_sched
  import tcp_sched_pkg::*;
#(
  parameter int FLOWS    = MAX_TCP_FLOWS,
  parameter int FLOWID_W = $clog2(FLOWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sched_cmd_val,
  input  logic [FLOWID_W-1:0]   sched_cmd_flowid,
  input  logic [SCHED_OP_W-1:0] sched_cmd_op,
  output logic                  sched_cmd_rdy,
  output logic                  sched_tx_req_val,
  output logic [FLOWID_W-1:0]   sched_tx_req_flowid,
  output logic                  sched_tx_req_rt,
  input  logic                  tx_sched_req_rdy,
  output logic                  o_dbg_state
);

  // Handshake: a grant transfers on a rising edge where sched_tx_req_val and
  // tx_sched_req_rdy are both high; until then flowid/rt are held unchanged.

  logic [FLOWS-1:0]    r_pend_data;
  logic [FLOWS-1:0]    r_pend_rt;
  logic [FLOWID_W-1:0] r_rr_ptr;
  sched_state_e        r_state;
  logic                r_val;
  logic [FLOWID_W-1:0] r_flowid;
  logic                r_rt;

  logic                w_handshake;
  logic [FLOWS-1:0]    w_hold_mask;
  logic [FLOWID_W-1:0] w_start;
  logic                w_rt_found;
  logic [FLOWID_W-1:0] w_rt_idx;
  logic                w_data_found;
  logic [FLOWID_W-1:0] w_data_idx;
  logic                w_cand_found;
  logic                w_cand_rt;
  logic [FLOWID_W-1:0] w_cand_idx;
  logic                w_load;
  logic [FLOWS-1:0]    w_load_mask;
  logic [FLOWS-1:0]    w_cmd_mask;
  logic [FLOWS-1:0]    w_pend_data_nxt;
  logic [FLOWS-1:0]    w_pend_rt_nxt;

  assign sched_cmd_rdy       = rst_n;
  assign sched_tx_req_val    = r_val;
  assign sched_tx_req_flowid = r_flowid;
  assign sched_tx_req_rt     = r_rt;
  assign o_dbg_state         = r_state;

  assign w_handshake = r_val & tx_sched_req_rdy;
  assign w_hold_mask = r_val ? (FLOWS'(1) << r_flowid) : '0;
  // On a handshake the search already starts past the granted flow.
  assign w_start     = w_handshake ? (r_flowid + FLOWID_W'(1)) : r_rr_ptr;

  rr_prio_enc #(.W(FLOWS), .IW(FLOWID_W)) u_enc_rt (
    .i_req   (r_pend_rt & ~w_hold_mask),
    .i_start (w_start),
    .o_found (w_rt_found),
    .o_idx   (w_rt_idx)
  );

  rr_prio_enc #(.W(FLOWS), .IW(FLOWID_W)) u_enc_data (
    .i_req   (r_pend_data & ~w_hold_mask),
    .i_start (w_start),
    .o_found (w_data_found),
    .o_idx   (w_data_idx)
  );

  assign w_cand_found = w_rt_found | w_data_found;
  assign w_cand_rt    = w_rt_found;
  assign w_cand_idx   = w_rt_found ? w_rt_idx : w_data_idx;
  assign w_load       = w_cand_found & ((r_state == ST_IDLE) | w_handshake);
  assign w_load_mask  = FLOWS'(1) << w_cand_idx;
  assign w_cmd_mask   = FLOWS'(1) << sched_cmd_flowid;

  // The load clears first so a same-cycle command on that flow wins.
  always_comb begin
    w_pend_data_nxt = r_pend_data;
    w_pend_rt_nxt   = r_pend_rt;
    if (w_load) begin
      if (w_cand_rt) w_pend_rt_nxt   = w_pend_rt_nxt & ~w_load_mask;
      else           w_pend_data_nxt = w_pend_data_nxt & ~w_load_mask;
    end
    if (sched_cmd_val) begin
      case (sched_op_e'(sched_cmd_op))
        SCHED_SET_DATA: w_pend_data_nxt = w_pend_data_nxt | w_cmd_mask;
        SCHED_SET_RT:   w_pend_rt_nxt   = w_pend_rt_nxt | w_cmd_mask;
        SCHED_CLR_ALL: begin
          w_pend_data_nxt = w_pend_data_nxt & ~w_cmd_mask;
          w_pend_rt_nxt   = w_pend_rt_nxt & ~w_cmd_mask;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_data <= '0;
      r_pend_rt   <= '0;
    end else begin
      r_pend_data <= w_pend_data_nxt;
      r_pend_rt   <= w_pend_rt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_val    <= 1'b0;
      r_flowid <= '0;
      r_rt     <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_val    <= 1'b1;
            r_flowid <= w_cand_idx;
            r_rt     <= w_cand_rt;
            r_state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_handshake) begin
            r_rr_ptr <= r_flowid + FLOWID_W'(1);
            if (w_load) begin
              r_flowid <= w_cand_idx;
              r_rt     <= w_cand_rt;
            end else begin
              r_val   <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_val   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_tx_flow_sched.sv
// Randomised and directed bench for tcp_tx_flow_sched with a queue-based
// reference model and a decoupled handshake monitor.
module tb_tcp_tx_flow_sched;
  import tcp_sched_pkg::*;

  localparam int F  = MAX_TCP_FLOWS;
  localparam int FW = $clog2(F);
  localparam int W  = $bits(sched_grant_struct);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_val = 1'b0;
  logic [FW-1:0] cmd_flowid = '0;
  logic [1:0]    cmd_op = 2'd0;
  logic          cmd_rdy;
  logic          req_val;
  logic [FW-1:0] req_flowid;
  logic          req_rt;
  logic          tx_rdy = 1'b0;
  logic          dbg_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference state: pending sets, round-robin start, and the offered grant.
  logic [F-1:0] m_data = '0;
  logic [F-1:0] m_rt   = '0;
  int           m_ptr  = 0;
  bit           m_val  = 1'b0;
  int           m_flow = 0;
  bit           m_grt  = 1'b0;

  bit            prev_hold = 1'b0;
  logic [FW-1:0] prev_flow = '0;
  logic          prev_rt   = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tcp_tx_flow_sched dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .sched_cmd_val       (cmd_val),
    .sched_cmd_flowid    (cmd_flowid),
    .sched_cmd_op        (cmd_op),
    .sched_cmd_rdy       (cmd_rdy),
    .sched_tx_req_val    (req_val),
    .sched_tx_req_flowid (req_flowid),
    .sched_tx_req_rt     (req_rt),
    .tx_sched_req_rdy    (tx_rdy),
    .o_dbg_state         (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int find_first(input logic [F-1:0] v, input int start, input int excl);
    for (int k = 0; k < F; k++) begin
      int idx;
      idx = (start + k) % F;
      if (idx != excl && v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit hs;
    int start;
    int excl;
    int c;
    bit crt;
    sched_grant_struct g;
    if (!rst_n) begin
      m_data = '0; m_rt = '0; m_ptr = 0; m_val = 1'b0; m_flow = 0; m_grt = 1'b0;
      exp_q.delete();
      return;
    end
    hs    = m_val && tx_rdy;
    start = hs ? (m_flow + 1) % F : m_ptr;
    if (hs) m_ptr = (m_flow + 1) % F;
    if (!m_val || hs) begin
      excl = m_val ? m_flow : -1;
      c    = find_first(m_rt, start, excl);
      crt  = 1'b1;
      if (c < 0) begin
        c   = find_first(m_data, start, excl);
        crt = 1'b0;
      end
      if (c >= 0) begin
        m_val  = 1'b1;
        m_flow = c;
        m_grt  = crt;
        if (crt) m_rt[c] = 1'b0;
        else     m_data[c] = 1'b0;
        g.flowid = c[FW-1:0];
        g.rt     = crt;
        exp_q.push_back(g);
      end else begin
        m_val = 1'b0;
      end
    end
    if (cmd_val) begin
      case (cmd_op)
        2'd1: m_data[cmd_flowid] = 1'b1;
        2'd2: m_rt[cmd_flowid]   = 1'b1;
        2'd3: begin
          m_data[cmd_flowid] = 1'b0;
          m_rt[cmd_flowid]   = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("val", req_val, m_val);
      chk("dbg_state", dbg_state, m_val);
      if (prev_hold) begin
        chk("hold_val", req_val, 1'b1);
        chk("hold_flowid", req_flowid, prev_flow);
        chk("hold_rt", req_rt, prev_rt);
      end
      if (req_val && tx_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", {req_flowid, req_rt}, 32'hffff_ffff);
        end else begin
          chk("grant", {req_flowid, req_rt}, exp_q.pop_front());
        end
      end
    end
    prev_hold = rst_n && req_val && !tx_rdy;
    prev_flow = req_flowid;
    prev_rt   = req_rt;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] op, input int f, input logic r);
    @(posedge clk);
    #1;
    cmd_val    = (op != 2'd0);
    cmd_op     = op;
    cmd_flowid = f[FW-1:0];
    tx_rdy     = r;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) drive(2'd0, 0, r);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_val", req_val, 1'b0);
    chk("rst_flowid", req_flowid, '0);
    chk("rst_rt", req_rt, 1'b0);
    chk("rst_cmd_rdy", cmd_rdy, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    #1;
    chk("cmd_rdy", cmd_rdy, 1'b1);

    // Latency: set in cycle 0, grant valid in cycle 2.
    drive(2'd1, 5, 1'b1);
    drive(2'd0, 0, 1'b1);
    chk("lat_c1_val", req_val, 1'b0);
    drive(2'd0, 0, 1'b1);
    chk("lat_c2_val", req_val, 1'b1);
    chk("lat_c2_flowid", req_flowid, 6'd5);
    chk("lat_c2_rt", req_rt, 1'b0);
    idle(4, 1'b1);

    // Burst of data sets, back-to-back grants.
    drive(2'd1, 3, 1'b1);
    drive(2'd1, 10, 1'b1);
    drive(2'd1, 60, 1'b1);
    idle(5, 1'b1);

    // Retransmit served before data while both pending behind a held grant.
    drive(2'd1, 30, 1'b0);
    drive(2'd1, 7, 1'b0);
    drive(2'd2, 20, 1'b0);
    idle(3, 1'b0);
    idle(6, 1'b1);

    // Round-robin wrap past the top flow.
    drive(2'd1, 62, 1'b0);
    drive(2'd1, 1, 1'b0);
    drive(2'd1, 63, 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // CLR_ALL on the held flow does not withdraw the grant.
    drive(2'd1, 4, 1'b0);
    idle(1, 1'b0);
    drive(2'd3, 4, 1'b0);
    idle(4, 1'b0);
    idle(6, 1'b1);

    // Re-set of a flow in the cycle it is loaded.
    drive(2'd1, 9, 1'b1);
    drive(2'd1, 9, 1'b1);
    idle(8, 1'b1);

    // Both classes set on one flow: two separate grants.
    drive(2'd1, 17, 1'b0);
    drive(2'd2, 17, 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // Asynchronous reset in the middle of a hold.
    drive(2'd1, 11, 1'b0);
    drive(2'd1, 12, 1'b0);
    idle(2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_val", req_val, 1'b0);
    chk("midrst_cmd_rdy", cmd_rdy, 1'b0);
    chk("midrst_state", dbg_state, ST_IDLE);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(8, 1'b1);

    // Randomised traffic, biased toward a few flows to provoke collisions.
    for (int n = 0; n < 800; n++) begin
      int f;
      f = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, F - 1);
      drive(2'($urandom_range(0, 3)), f, ($urandom_range(0, 3) != 0));
    end

    idle(2 * F + 10, 1'b1);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_val", req_val, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
